// File: rtl/sram_req_adapter_if.sv
// Handshake bundle between a pipeline SRAM-style port and a variable-latency memory bus.
// slave: adapter view (takes the cpu request and the bus response, drives the bus request and read data).
// master: environment view (the pipeline plus the bus model), with every direction reversed.
interface sram_req_adapter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            flush;
    logic            cpu_en;
    logic [DW/8-1:0] cpu_we;
    logic [AW-1:0]   cpu_addr;
    logic [DW-1:0]   cpu_wdata;
    logic            stallreq;
    logic            cpu_rvalid;
    logic [DW-1:0]   cpu_rdata;
    logic            bus_req;
    logic [DW/8-1:0] bus_we;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_wdata;
    logic            bus_gnt;
    logic            bus_rvalid;
    logic [DW-1:0]   bus_rdata;
    logic            busy;
    logic [1:0]      err;

    modport slave (
        input  flush, cpu_en, cpu_we, cpu_addr, cpu_wdata, bus_gnt, bus_rvalid, bus_rdata,
        output stallreq, cpu_rvalid, cpu_rdata, bus_req, bus_we, bus_addr, bus_wdata, busy, err
    );

    modport master (
        output flush, cpu_en, cpu_we, cpu_addr, cpu_wdata, bus_gnt, bus_rvalid, bus_rdata,
        input  stallreq, cpu_rvalid, cpu_rdata, bus_req, bus_we, bus_addr, bus_wdata, busy, err
    );
endinterface

// File: rtl/sram_req_adapter.sv
// Adapts a pipeline SRAM port to a granted, in-order-response bus and tracks up to DEPTH outstanding accesses.
// Latency: the issue path is combinational; cpu_rvalid is registered one cycle after the accepting bus_rvalid.
// Backpressure: stallreq is raised while cpu_en is set and the access is not issued (FIFO full or no bus_gnt).
// Ports: clk, rst_n (synchronous, active-low); sif (slave modport) carries flush, the cpu_* request,
//        stallreq, cpu_rvalid/cpu_rdata, the bus_* request/response, busy and sticky err {timeout, spurious}.
// Optional: define SRAM_ADAPTER_TIMEOUT_EN to abort the head entry after TIMEOUT cycles without a response.
module sram_req_adapter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_req_adapter_if.slave sif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Reject parameter sets the pointer arithmetic and the wait counter cannot handle.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1) || ((DW % 8) != 0)) begin : g_bad_param
        $error("sram_req_adapter: DEPTH must be a power of 2 >= 2, TIMEOUT >= 1, DW a multiple of 8");
    end

    // Tag FIFO held as flat per-entry bits, so a flush can mark every entry dropped in one cycle.
    logic [DEPTH-1:0] tag_rd;
    logic [DEPTH-1:0] tag_drop;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic             rvalid_q;
    logic [DW-1:0]    rdata_q;
    logic [1:0]       err_q;

    logic full;
    logic issue;
    logic rsp_pop;
    logic tmo_pop;
    logic pop;
    logic head_fwd;
    logic spurious;

    assign full     = (count == CW'(DEPTH));
    assign sif.bus_req   = rst_n & sif.cpu_en & ~full & ~sif.flush;
    assign issue    = sif.bus_req & sif.bus_gnt;
    assign sif.stallreq  = sif.cpu_en & ~issue & ~sif.flush;

    assign rsp_pop  = sif.bus_rvalid & (count != '0);
    assign pop      = rsp_pop | tmo_pop;
    // A head entry popped in the same cycle as a flush belongs to a killed access.
    assign head_fwd = tag_rd[rd_ptr] & ~tag_drop[rd_ptr] & ~sif.flush;
    // A response that arrives together with the first issue into an empty FIFO is not counted as spurious.
    assign spurious = sif.bus_rvalid & (count == '0) & ~issue;

    assign sif.bus_we     = sif.cpu_we;
    assign sif.bus_addr   = sif.cpu_addr[AW-1:0];
    assign sif.bus_wdata  = sif.cpu_wdata[DW-1:0];
    assign sif.cpu_rvalid = rvalid_q;
    assign sif.cpu_rdata  = rdata_q;
    assign sif.busy       = (count != '0);
    assign sif.err        = err_q;

`ifdef SRAM_ADAPTER_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wait_cnt;

    // Fire on the cycle whose increment would take the counter to TIMEOUT, so the abort
    // response appears TIMEOUT+1 cycles after issue, mirroring a real response at that edge.
    assign tmo_pop = (count != '0) & ~sif.bus_rvalid & (wait_cnt == WW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if ((count == '0) || pop) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end
`else
    assign tmo_pop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_rd   <= '0;
            tag_drop <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= '0;
        end else begin
            // Unused slots may be marked too; they are rewritten on push. Push never coincides with flush.
            if (sif.flush) begin
                tag_drop <= '1;
            end
            if (issue) begin
                tag_rd[wr_ptr]   <= (sif.cpu_we == '0);
                tag_drop[wr_ptr] <= 1'b0;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({issue, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            rvalid_q <= pop & head_fwd;
            if (pop & head_fwd) begin
                rdata_q <= tmo_pop ? {(DW/32){32'hDEADBEEF}} : sif.bus_rdata;
            end

            if (spurious) begin
                err_q[0] <= 1'b1;
            end
            if (tmo_pop) begin
                err_q[1] <= 1'b1;
            end
        end
    end
endmodule
